// File: rtl/axi4_ram_responder.sv
// AXI4 slave RAM: word array behind independent read and write burst engines.
// FIXED bursts hold the word index; INCR and WRAP advance it by one word per beat, modulo depth.
module axi4_ram_responder #(
    parameter int RAM_DATA_WIDTH = 32,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int RAM_STRB_WIDTH = RAM_DATA_WIDTH / 8,
    parameter int RAM_ID_WIDTH   = 8
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [RAM_ID_WIDTH-1:0]   s_axi_awid,
    input  logic [RAM_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [RAM_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [RAM_STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [RAM_ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [RAM_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [RAM_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [RAM_ID_WIDTH-1:0]   s_axi_rid,
    output logic [RAM_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);
    localparam int IDX_LSB = $clog2(RAM_STRB_WIDTH);
    localparam int IDX_W   = RAM_ADDR_WIDTH - IDX_LSB;
    localparam int DEPTH   = 2 ** IDX_W;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [RAM_DATA_WIDTH-1:0] mem [DEPTH];

    w_state_t w_state_reg, w_state_next;
    r_state_t r_state_reg, r_state_next;

    logic awready_reg, awready_next, wready_reg, wready_next, bvalid_reg, bvalid_next;
    logic arready_reg, arready_next, rvalid_reg, rvalid_next;
    logic [RAM_ID_WIDTH-1:0]   aw_id_reg, bid_reg, rid_reg;
    logic [1:0]                bresp_reg;
    logic [IDX_W-1:0]          w_idx_reg, r_idx_reg, rd_idx;
    logic [7:0]                w_len_reg, w_cnt_reg, r_len_reg, r_cnt_reg;
    logic                      w_fixed_reg, w_err_reg, r_fixed_reg, rlast_reg;
    logic [RAM_DATA_WIDTH-1:0] rdata_reg;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_final, w_beat_err;
    logic unused_ok;

    assign aw_hs      = s_axi_awvalid & awready_reg;
    assign w_hs       = s_axi_wvalid & wready_reg;
    assign b_hs       = bvalid_reg & s_axi_bready;
    assign ar_hs      = s_axi_arvalid & arready_reg;
    assign r_hs       = rvalid_reg & s_axi_rready;
    assign w_final    = (w_cnt_reg == w_len_reg);
    // wlast must coincide exactly with the counted final beat
    assign w_beat_err = s_axi_wlast ^ w_final;

    // Size is ignored and sub-word address bits carry no meaning here.
    assign unused_ok = ^{s_axi_awsize, s_axi_arsize, s_axi_awaddr, s_axi_araddr};

    // ---------------- write channel ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_reg <= W_IDLE;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
        end else begin
            w_state_reg <= w_state_next;
            awready_reg <= awready_next;
            wready_reg  <= wready_next;
            bvalid_reg  <= bvalid_next;
        end
    end

    always_comb begin
        w_state_next = w_state_reg;
        case (w_state_reg)
            W_IDLE:  if (aw_hs) w_state_next = W_DATA;
            W_DATA:  if (w_hs && w_final) w_state_next = W_RESP;
            W_RESP:  if (b_hs) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        awready_next = (w_state_next == W_IDLE);
        wready_next  = (w_state_next == W_DATA);
        bvalid_next  = (w_state_next == W_RESP);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_id_reg   <= '0;
            w_idx_reg   <= '0;
            w_len_reg   <= '0;
            w_cnt_reg   <= '0;
            w_fixed_reg <= 1'b0;
            w_err_reg   <= 1'b0;
            bid_reg     <= '0;
            bresp_reg   <= 2'b00;
        end else if (aw_hs) begin
            aw_id_reg   <= s_axi_awid;
            w_idx_reg   <= s_axi_awaddr[RAM_ADDR_WIDTH-1:IDX_LSB];
            w_len_reg   <= s_axi_awlen;
            w_cnt_reg   <= '0;
            w_fixed_reg <= (s_axi_awburst == BURST_FIXED);
            w_err_reg   <= 1'b0;
        end else if (w_hs) begin
            w_idx_reg <= w_fixed_reg ? w_idx_reg : w_idx_reg + IDX_W'(1);
            w_cnt_reg <= w_cnt_reg + 8'd1;
            w_err_reg <= w_err_reg | w_beat_err;
            if (w_final) begin
                bid_reg   <= aw_id_reg;
                bresp_reg <= (w_err_reg | w_beat_err) ? 2'b10 : 2'b00;
            end
        end
    end

    // Array itself is never reset so contents survive aresetn.
    always_ff @(posedge aclk) begin
        if (w_hs) begin
            for (int i = 0; i < RAM_STRB_WIDTH; i++) begin
                if (s_axi_wstrb[i]) mem[w_idx_reg][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_reg <= R_IDLE;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
        end else begin
            r_state_reg <= r_state_next;
            arready_reg <= arready_next;
            rvalid_reg  <= rvalid_next;
        end
    end

    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_IDLE:  if (ar_hs) r_state_next = R_DATA;
            R_DATA:  if (r_hs && rlast_reg) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        arready_next = (r_state_next == R_IDLE);
        rvalid_next  = (r_state_next == R_DATA);
    end

    assign rd_idx = ar_hs ? s_axi_araddr[RAM_ADDR_WIDTH-1:IDX_LSB] : r_idx_reg;

    // r_idx_reg always points at the word for the beat after the one presented.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rid_reg     <= '0;
            r_idx_reg   <= '0;
            r_len_reg   <= '0;
            r_cnt_reg   <= '0;
            r_fixed_reg <= 1'b0;
            rlast_reg   <= 1'b0;
            rdata_reg   <= '0;
        end else if (ar_hs) begin
            rid_reg     <= s_axi_arid;
            r_len_reg   <= s_axi_arlen;
            r_cnt_reg   <= '0;
            r_fixed_reg <= (s_axi_arburst == BURST_FIXED);
            rlast_reg   <= (s_axi_arlen == 8'd0);
            rdata_reg   <= mem[rd_idx];
            r_idx_reg   <= (s_axi_arburst == BURST_FIXED) ? rd_idx : rd_idx + IDX_W'(1);
        end else if (r_hs) begin
            if (rlast_reg) begin
                rlast_reg <= 1'b0;
            end else begin
                rdata_reg <= mem[rd_idx];
                r_idx_reg <= r_fixed_reg ? r_idx_reg : r_idx_reg + IDX_W'(1);
                r_cnt_reg <= r_cnt_reg + 8'd1;
                rlast_reg <= ((r_cnt_reg + 8'd1) == r_len_reg);
            end
        end
    end

    assign s_axi_awready = awready_reg;
    assign s_axi_wready  = wready_reg;
    assign s_axi_bvalid  = bvalid_reg;
    assign s_axi_bid     = bid_reg;
    assign s_axi_bresp   = bresp_reg;
    assign s_axi_arready = arready_reg;
    assign s_axi_rvalid  = rvalid_reg;
    assign s_axi_rid     = rid_reg;
    assign s_axi_rdata   = rdata_reg;
    assign s_axi_rlast   = rlast_reg;
    assign s_axi_rresp   = 2'b00;

endmodule

// File: tb/tb_axi4_ram_responder.sv
// Directed plus randomized bench for axi4_ram_responder against a word-array model.
module tb_axi4_ram_responder;
    localparam int DW = 32, AW = 16, SW = 4, IW = 8;
    localparam int DEPTH = 1 << 14;
    localparam int LIMIT = 50;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [IW-1:0] s_axi_awid = '0, s_axi_arid = '0, s_axi_bid, s_axi_rid;
    logic [AW-1:0] s_axi_awaddr = '0, s_axi_araddr = '0;
    logic [7:0]    s_axi_awlen = '0, s_axi_arlen = '0;
    logic [2:0]    s_axi_awsize = 3'd2, s_axi_arsize = 3'd2;
    logic [1:0]    s_axi_awburst = 2'b01, s_axi_arburst = 2'b01, s_axi_bresp, s_axi_rresp;
    logic          s_axi_awvalid = 1'b0, s_axi_awready;
    logic [DW-1:0] s_axi_wdata = '0, s_axi_rdata;
    logic [SW-1:0] s_axi_wstrb = '0;
    logic          s_axi_wlast = 1'b0, s_axi_wvalid = 1'b0, s_axi_wready;
    logic          s_axi_bvalid, s_axi_bready = 1'b0;
    logic          s_axi_arvalid = 1'b0, s_axi_arready;
    logic          s_axi_rlast, s_axi_rvalid, s_axi_rready = 1'b0;

    axi4_ram_responder #(
        .RAM_DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW), .RAM_STRB_WIDTH(SW), .RAM_ID_WIDTH(IW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 aclk = ~aclk;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] ref_mem [int];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timed_out(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: observed=no handshake expected=handshake within %0d cycles", tag, LIMIT);
    endtask

    function automatic int widx(input logic [15:0] a);
        return int'(a[15:2]);
    endfunction

    task automatic send_aw(input logic [7:0] id, input logic [15:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        while (s_axi_awready !== 1'b1 && n < LIMIT) begin @(negedge aclk); n++; end
        if (n >= LIMIT) timed_out("aw_timeout");
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [15:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        while (s_axi_arready !== 1'b1 && n < LIMIT) begin @(negedge aclk); n++; end
        if (n >= LIMIT) timed_out("ar_timeout");
        @(negedge aclk);
        s_axi_arvalid = 1'b0;
    endtask

    // Drives one write burst from wd/ws; bad_wlast puts wlast on beat 0 only.
    task automatic write_burst(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input bit bad_wlast);
        int idx = widx(addr);
        int n;
        logic [1:0] exp_resp = 2'b00;
        logic [31:0] cur;
        send_aw(id, addr, len, burst);
        check("wready_after_aw", 32'(s_axi_wready), 32'd1);
        for (int b = 0; b <= int'(len); b++) begin
            s_axi_wdata = wd[b]; s_axi_wstrb = ws[b];
            s_axi_wlast = bad_wlast ? (b == 0) : (b == int'(len));
            s_axi_wvalid = 1'b1;
            n = 0;
            while (s_axi_wready !== 1'b1 && n < LIMIT) begin @(negedge aclk); n++; end
            if (n >= LIMIT) timed_out("w_timeout");
            @(negedge aclk);
            cur = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
            for (int l = 0; l < 4; l++) if (ws[b][l]) cur[l*8 +: 8] = wd[b][l*8 +: 8];
            ref_mem[idx] = cur;
            if (s_axi_wlast != (b == int'(len))) exp_resp = 2'b10;
            if (burst != 2'b00) idx = (idx + 1) % DEPTH;
            s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        end
        check("bvalid_after_last", 32'(s_axi_bvalid), 32'd1);
        check("bid", 32'(s_axi_bid), 32'(id));
        check("bresp", 32'(s_axi_bresp), 32'(exp_resp));
        repeat ($urandom_range(0, 2)) begin
            @(negedge aclk);
            check("bvalid_hold", 32'(s_axi_bvalid), 32'd1);
        end
        s_axi_bready = 1'b1;
        @(negedge aclk);
        s_axi_bready = 1'b0;
        check("bvalid_clear", 32'(s_axi_bvalid), 32'd0);
        check("awready_back", 32'(s_axi_awready), 32'd1);
        $display("write id=%h addr=%h len=%0d burst=%0d bresp=%0d", id, addr, len, burst, s_axi_bresp);
    endtask

    // alt=1 drives rready 1,0,1,0...; alt=0 drives random rready.
    task automatic read_burst(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input bit alt);
        int idx = widx(addr);
        bit toggle = 1'b1;
        bit rr;
        int stalls;
        send_ar(id, addr, len, burst);
        for (int b = 0; b <= int'(len); b++) begin
            rr = 1'b0;
            stalls = 0;
            while (!rr) begin
                check("rvalid", 32'(s_axi_rvalid), 32'd1);
                check("rdata", s_axi_rdata, ref_mem[idx]);
                check("rlast", 32'(s_axi_rlast), 32'(b == int'(len)));
                check("rid", 32'(s_axi_rid), 32'(id));
                rr = alt ? toggle : 1'($urandom_range(0, 1));
                if (stalls >= 4) rr = 1'b1;
                toggle = ~toggle;
                s_axi_rready = rr;
                @(negedge aclk);
                s_axi_rready = 1'b0;
                stalls++;
            end
            if (burst != 2'b00) idx = (idx + 1) % DEPTH;
        end
        check("rvalid_clear", 32'(s_axi_rvalid), 32'd0);
        check("arready_back", 32'(s_axi_arready), 32'd1);
        $display("read  id=%h addr=%h len=%0d burst=%0d", id, addr, len, burst);
    endtask

    task automatic check_all_idle(input string tag);
        check({tag, "_awready"}, 32'(s_axi_awready), 32'd0);
        check({tag, "_wready"},  32'(s_axi_wready),  32'd0);
        check({tag, "_bvalid"},  32'(s_axi_bvalid),  32'd0);
        check({tag, "_arready"}, 32'(s_axi_arready), 32'd0);
        check({tag, "_rvalid"},  32'(s_axi_rvalid),  32'd0);
        check({tag, "_rlast"},   32'(s_axi_rlast),   32'd0);
    endtask

    initial begin
        logic [31:0] old_word;
        logic [15:0] a;
        logic [7:0]  len;
        logic [1:0]  burst;

        // Reset state and release timing
        repeat (3) @(negedge aclk);
        check_all_idle("reset");
        check("reset_bresp", 32'(s_axi_bresp), 32'd0);
        check("reset_rresp", 32'(s_axi_rresp), 32'd0);
        check("reset_bid", 32'(s_axi_bid), 32'd0);
        check("reset_rid", 32'(s_axi_rid), 32'd0);
        check("reset_rdata", s_axi_rdata, 32'd0);
        aresetn = 1'b1;
        check("release_awready", 32'(s_axi_awready), 32'd0);
        @(negedge aclk);
        check("ready_awready", 32'(s_axi_awready), 32'd1);
        check("ready_arready", 32'(s_axi_arready), 32'd1);

        // Single write then read
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        write_burst(8'h03, 16'h0010, 8'd0, 2'b01, 1'b0);
        read_burst(8'h03, 16'h0010, 8'd0, 2'b01, 1'b0);

        // INCR burst with alternating rready
        for (int b = 0; b < 4; b++) begin wd[b] = 32'(b + 1); ws[b] = 4'hF; end
        write_burst(8'h11, 16'h0100, 8'd3, 2'b01, 1'b0);
        read_burst(8'h12, 16'h0100, 8'd3, 2'b01, 1'b1);

        // Byte strobes
        wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
        write_burst(8'h20, 16'h0020, 8'd0, 2'b01, 1'b0);
        wd[0] = 32'h11223344; ws[0] = 4'h5;
        write_burst(8'h21, 16'h0020, 8'd0, 2'b01, 1'b0);
        read_burst(8'h22, 16'h0020, 8'd0, 2'b01, 1'b0);

        // FIXED burst rewrites one word
        wd[0] = 32'd5; wd[1] = 32'd6; ws[0] = 4'hF; ws[1] = 4'hF;
        write_burst(8'h30, 16'h0030, 8'd1, 2'b00, 1'b0);
        read_burst(8'h31, 16'h0030, 8'd0, 2'b01, 1'b0);
        read_burst(8'h32, 16'h0034, 8'd0, 2'b01, 1'b0);

        // Index wrap from the top word
        wd[0] = 32'h77; wd[1] = 32'h88; ws[0] = 4'hF; ws[1] = 4'hF;
        write_burst(8'h40, 16'hFFFC, 8'd1, 2'b01, 1'b0);
        read_burst(8'h41, 16'h0000, 8'd0, 2'b01, 1'b0);
        read_burst(8'h42, 16'hFFFC, 8'd1, 2'b10, 1'b1);

        // Early wlast gives SLVERR but both beats land
        wd[0] = 32'hCAFE0001; wd[1] = 32'hCAFE0002; ws[0] = 4'hF; ws[1] = 4'hF;
        write_burst(8'h50, 16'h0050, 8'd1, 2'b01, 1'b1);
        read_burst(8'h51, 16'h0050, 8'd1, 2'b01, 1'b0);

        // Same-edge write commit and read registration on one word
        wd[0] = 32'h1; ws[0] = 4'hF;
        write_burst(8'h60, 16'h0040, 8'd0, 2'b01, 1'b0);
        old_word = ref_mem[widx(16'h0040)];
        s_axi_awid = 8'h05; s_axi_awaddr = 16'h0040; s_axi_awlen = 8'd0; s_axi_awburst = 2'b01;
        s_axi_awvalid = 1'b1;
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
        check("coll_wready", 32'(s_axi_wready), 32'd1);
        check("coll_arready", 32'(s_axi_arready), 32'd1);
        s_axi_wdata = 32'h2; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
        s_axi_arid = 8'h06; s_axi_araddr = 16'h0040; s_axi_arlen = 8'd0; s_axi_arburst = 2'b01;
        s_axi_arvalid = 1'b1;
        @(negedge aclk);
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
        check("coll_rvalid", 32'(s_axi_rvalid), 32'd1);
        check("coll_rdata_old", s_axi_rdata, old_word);
        check("coll_rid", 32'(s_axi_rid), 32'h06);
        check("coll_bvalid", 32'(s_axi_bvalid), 32'd1);
        check("coll_bid", 32'(s_axi_bid), 32'h05);
        check("coll_bresp", 32'(s_axi_bresp), 32'd0);
        ref_mem[widx(16'h0040)] = 32'h2;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        @(negedge aclk);
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        check("coll_bvalid_clear", 32'(s_axi_bvalid), 32'd0);
        check("coll_rvalid_clear", 32'(s_axi_rvalid), 32'd0);
        check("coll_awready", 32'(s_axi_awready), 32'd1);
        check("coll_arready_back", 32'(s_axi_arready), 32'd1);
        $display("collision wid=05 rid=06 addr=0040 read_old=%h", s_axi_rdata);
        read_burst(8'h07, 16'h0040, 8'd0, 2'b01, 1'b0);

        // Randomized bursts: full-strobe fill, random-strobe overwrite, read back
        for (int t = 0; t < 12; t++) begin
            a = 16'($urandom) & 16'hFFFC;
            len = 8'($urandom_range(0, 7));
            burst = 2'($urandom_range(0, 2));
            for (int b = 0; b <= int'(len); b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
            write_burst(8'(t), a, len, burst, 1'b0);
            for (int b = 0; b <= int'(len); b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
            write_burst(8'(t + 100), a, len, burst, 1'b0);
            read_burst(8'(t + 200), a, len, burst, 1'b0);
        end

        // Reset during the second beat of a 4-beat write
        for (int b = 0; b < 4; b++) begin wd[b] = 32'hA0 + 32'(b); ws[b] = 4'hF; end
        write_burst(8'h08, 16'h0200, 8'd3, 2'b01, 1'b0);
        send_aw(8'h09, 16'h0200, 8'd3, 2'b01);
        s_axi_wdata = 32'h11; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
        @(negedge aclk);
        ref_mem[widx(16'h0200)] = 32'h11;
        s_axi_wdata = 32'h22;
        #2 aresetn = 1'b0;
        #1 check_all_idle("midreset");
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        s_axi_wvalid = 1'b0;
        check("rel_awready", 32'(s_axi_awready), 32'd0);
        check("rel_arready", 32'(s_axi_arready), 32'd0);
        @(negedge aclk);
        check("post_awready", 32'(s_axi_awready), 32'd1);
        check("post_arready", 32'(s_axi_arready), 32'd1);
        check("post_bvalid", 32'(s_axi_bvalid), 32'd0);
        check("post_wready", 32'(s_axi_wready), 32'd0);
        $display("reset mid-burst addr=0200 beats_committed=1");
        read_burst(8'h0A, 16'h0200, 8'd3, 2'b01, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
